// File: rtl/spi_slave_ctrl_pkg.sv
// Shared encodings for the SPI slave control path: FSM states, chip-select
// polarity and the R/W bit meaning.
package spi_slave_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD       = 3'd1,
    ST_RD_LOAD   = 3'd2,
    ST_RD_SHIFT  = 3'd3,
    ST_WR_SHIFT  = 3'd4,
    ST_WR_COMMIT = 3'd5,
    ST_WR_INC    = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  localparam logic CSON     = 1'b0;
  localparam logic CSOFF    = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Conditioned SPI inputs and datapath control strobes between the
// input conditioner / datapath (master side) and the control FSM (slave side).
interface spi_slave_ctrl_if;
  logic cs;
  logic sclk_rise;
  logic sclk_fall;
  logic mosi;
  logic sr_shift;
  logic sr_load;
  logic addr_we;
  logic addr_inc;
  logic dm_we;
  logic miso_oe;
  logic rw;
  logic busy;

  modport master (
    output cs, sclk_rise, sclk_fall, mosi,
    input  sr_shift, sr_load, addr_we, addr_inc, dm_we, miso_oe, rw, busy
  );

  modport slave (
    input  cs, sclk_rise, sclk_fall, mosi,
    output sr_shift, sr_load, addr_we, addr_inc, dm_we, miso_oe, rw, busy
  );
endinterface

// File: rtl/spi_slave_ctrl_bit_counter.sv
// Bit counter with a fixed terminal value; tc fires with the increment that
// completes TERM bits and the count returns to zero on that same edge.
module spi_bit_counter #(
  parameter int W    = 4,
  parameter int TERM = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic tc
);
  logic [W-1:0] cnt_q, cnt_d;

  assign tc = inc && !clr && (cnt_q == W'(TERM - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc)
      cnt_d = '0;
    else if (inc)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_slave_ctrl.sv
// Control FSM for the SPI slave datapath: command (address + R/W) phase,
// then read or write data phases with optional burst address increment.
module spi_slave_ctrl
  import spi_slave_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8,
  parameter int BURST     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(max2(ADDR_BITS + 1, DATA_BITS) + 1);

  state_e state_q, state_d;
  logic sr_shift_q, sr_shift_d;
  logic sr_load_q,  sr_load_d;
  logic addr_we_q,  addr_we_d;
  logic addr_inc_q, addr_inc_d;
  logic dm_we_q,    dm_we_d;
  logic miso_oe_q,  miso_oe_d;
  logic rw_q,       rw_d;

  logic cs_off;
  logic cmd_inc, cmd_clr, cmd_tc;
  logic dat_inc, dat_clr, dat_tc;

  assign cs_off = (bus.cs == CSOFF);

  // Command and data phases count against different terminals, so each
  // gets its own counter; each is held clear outside its own phase.
  assign cmd_inc = !cs_off && (state_q == ST_CMD) && bus.sclk_rise;
  assign cmd_clr = cs_off || (state_q != ST_CMD);
  assign dat_inc = !cs_off &&
                   (((state_q == ST_RD_SHIFT) && bus.sclk_fall) ||
                    ((state_q == ST_WR_SHIFT) && bus.sclk_rise));
  assign dat_clr = cs_off ||
                   !((state_q == ST_RD_SHIFT) || (state_q == ST_WR_SHIFT));

  spi_bit_counter #(.W(CNT_W), .TERM(ADDR_BITS + 1)) u_cmd_cnt (
    .clk(clk), .rst_n(rst_n), .inc(cmd_inc), .clr(cmd_clr), .tc(cmd_tc)
  );

  spi_bit_counter #(.W(CNT_W), .TERM(DATA_BITS)) u_dat_cnt (
    .clk(clk), .rst_n(rst_n), .inc(dat_inc), .clr(dat_clr), .tc(dat_tc)
  );

  always_comb begin
    state_d    = state_q;
    sr_shift_d = 1'b0;
    sr_load_d  = 1'b0;
    addr_we_d  = 1'b0;
    addr_inc_d = 1'b0;
    dm_we_d    = 1'b0;
    miso_oe_d  = miso_oe_q;
    rw_d       = rw_q;
    if (cs_off) begin
      state_d   = ST_IDLE;
      miso_oe_d = 1'b0;
      rw_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          sr_shift_d = bus.sclk_rise;
          if (cmd_tc) begin
            rw_d      = bus.mosi;
            addr_we_d = 1'b1;
            state_d   = (bus.mosi == RW_READ) ? ST_RD_LOAD : ST_WR_SHIFT;
          end
        end
        // Address latch is written this cycle; memory data is ready next.
        ST_RD_LOAD: begin
          sr_load_d = 1'b1;
          miso_oe_d = 1'b1;
          state_d   = ST_RD_SHIFT;
        end
        ST_RD_SHIFT: begin
          sr_shift_d = bus.sclk_fall;
          if (dat_tc) begin
            if (BURST != 0) begin
              addr_inc_d = 1'b1;
              state_d    = ST_RD_LOAD;
            end else begin
              state_d    = ST_DONE;
            end
          end
        end
        ST_WR_SHIFT: begin
          sr_shift_d = bus.sclk_rise;
          if (dat_tc) begin
            dm_we_d = 1'b1;
            state_d = ST_WR_COMMIT;
          end
        end
        // dm_we is high here; increment only after the write has landed.
        ST_WR_COMMIT: begin
          if (BURST != 0) begin
            addr_inc_d = 1'b1;
            state_d    = ST_WR_INC;
          end else begin
            state_d    = ST_DONE;
          end
        end
        ST_WR_INC: state_d = ST_WR_SHIFT;
        ST_DONE:   state_d = ST_DONE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sr_shift_q <= 1'b0;
      sr_load_q  <= 1'b0;
      addr_we_q  <= 1'b0;
      addr_inc_q <= 1'b0;
      dm_we_q    <= 1'b0;
      miso_oe_q  <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_shift_q <= sr_shift_d;
      sr_load_q  <= sr_load_d;
      addr_we_q  <= addr_we_d;
      addr_inc_q <= addr_inc_d;
      dm_we_q    <= dm_we_d;
      miso_oe_q  <= miso_oe_d;
      rw_q       <= rw_d;
    end
  end

  assign bus.sr_shift = sr_shift_q;
  assign bus.sr_load  = sr_load_q;
  assign bus.addr_we  = addr_we_q;
  assign bus.addr_inc = addr_inc_q;
  assign bus.dm_we    = dm_we_q;
  assign bus.miso_oe  = miso_oe_q;
  assign bus.rw       = rw_q;
  assign bus.busy     = (state_q != ST_IDLE);
endmodule
